// File: rtl/yuv_pkg.sv
// ---------------------------------------------------------------------------
// yuv_pkg
// Definitions shared by the 4:4:4 -> 4:2:2 packer and the 4:2:2 -> 4:4:4
// unpacker: the pairing state encoding, the 16-bit word field positions
// and a helper that builds a word from its luma and chroma bytes.
// ---------------------------------------------------------------------------
package yuv_pkg;

  // Pairing state: EVEN = nothing held, ODD = first pixel of a pair held,
  // SECOND = word0 on the output, word1 waiting in the pending register.
  typedef enum logic [1:0] {
    ST_EVEN   = 2'd0,
    ST_ODD    = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  // Field positions inside a packed 4:2:2 word.
  localparam int Y_MSB = 15;
  localparam int Y_LSB = 8;
  localparam int C_MSB = 7;
  localparam int C_LSB = 0;

  // Build a 4:2:2 word: luma in the upper byte, chroma in the lower byte.
  function automatic logic [15:0] pack_word(input logic [7:0] y, input logic [7:0] c);
    logic [15:0] w;
    w = 16'h0000;
    w[Y_MSB:Y_LSB] = y;
    w[C_MSB:C_LSB] = c;
    return w;
  endfunction

endpackage

// File: rtl/chroma_avg2.sv
// ---------------------------------------------------------------------------
// chroma_avg2
// Two-tap chroma reducer for one chroma channel of a pixel pair.
//   a       : chroma of the even (first) pixel
//   b       : chroma of the odd (second) pixel
//   y       : reduced chroma
// AVERAGE=1 gives the rounded mean (a+b+1)>>1; AVERAGE=0 keeps the
// co-sited even sample.
// ---------------------------------------------------------------------------
module chroma_avg2 #(
  parameter int AVERAGE = 1
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [8:0] sum_s;

  // Nine-bit sum keeps the carry; after the shift the result always fits
  // in eight bits (255+255+1 = 511 -> 255).
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + 9'd1;
    if (AVERAGE != 0) begin
      y = sum_s[8:1];
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/yuv444_to_yuv422.sv
// ---------------------------------------------------------------------------
// yuv444_to_yuv422
// Packs a 4:4:4 pixel stream into 16-bit 4:2:2 words, one word per pixel:
// even word = {Y0, Cb}, odd word = {Y1, Cr}. Pairs are aligned to line
// starts; a line with an odd pixel count drops its last pixel and raises
// a sticky error flag.
// Ports:
//   iCLK, iRST            clock, asynchronous active-high reset
//   iY, iCb, iCr, iSOL    input pixel and start-of-line marker
//   iVALID / oREADY       input handshake
//   oYCbCr, oSOL          packed output word and its start-of-line marker
//   oVALID / iREADY       output handshake
//   oERR                  sticky: odd-length line seen (cleared by reset)
// ---------------------------------------------------------------------------
module yuv444_to_yuv422
  import yuv_pkg::*;
#(
  parameter int AVERAGE = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [7:0]  iY,
  input  logic [7:0]  iCb,
  input  logic [7:0]  iCr,
  input  logic        iSOL,
  input  logic        iVALID,
  output logic        oREADY,
  output logic [15:0] oYCbCr,
  output logic        oSOL,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oERR
);

  state_t      state_r;
  state_t      state_next_s;

  logic [7:0]  p0_y_r;
  logic [7:0]  p0_cb_r;
  logic [7:0]  p0_cr_r;
  logic        p0_sol_r;
  logic [15:0] pend_r;
  logic        pend_valid_r;
  logic [15:0] word_r;
  logic        sol_r;
  logic        valid_r;
  logic        err_r;

  logic        ready_s;
  logic        in_hs_s;
  logic        out_hs_s;
  logic [7:0]  c_b_s;
  logic [7:0]  c_r_s;
  logic        load_p0_s;
  logic        load_word0_s;
  logic        load_word1_s;
  logic        set_err_s;

  // Chroma of the held even pixel combined with the incoming odd pixel.
  chroma_avg2 #(.AVERAGE(AVERAGE)) u_avg_cb (.a(p0_cb_r), .b(iCb), .y(c_b_s));
  chroma_avg2 #(.AVERAGE(AVERAGE)) u_avg_cr (.a(p0_cr_r), .b(iCr), .y(c_r_s));

  // Input readiness. In SECOND the output register must drain word0 before
  // word1 can replace it, so only a downstream accept frees a slot.
  always_comb begin
    case (state_r)
      ST_SECOND: ready_s = iREADY;
      default:   ready_s = !valid_r | iREADY;
    endcase
  end

  assign in_hs_s  = iVALID & ready_s;
  assign out_hs_s = valid_r & iREADY;

  // Next-state and load-enable decode for the pairing FSM.
  always_comb begin
    state_next_s = state_r;
    load_p0_s    = 1'b0;
    load_word0_s = 1'b0;
    load_word1_s = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      ST_EVEN: begin
        if (in_hs_s) begin
          load_p0_s    = 1'b1;
          state_next_s = ST_ODD;
        end else begin
          state_next_s = ST_EVEN;
        end
      end
      ST_ODD: begin
        if (in_hs_s && iSOL) begin
          // New line began while a pixel was still unpaired: drop it.
          load_p0_s    = 1'b1;
          set_err_s    = 1'b1;
          state_next_s = ST_ODD;
        end else if (in_hs_s) begin
          load_word0_s = 1'b1;
          state_next_s = ST_SECOND;
        end else begin
          state_next_s = ST_ODD;
        end
      end
      ST_SECOND: begin
        if (out_hs_s) begin
          load_word1_s = pend_valid_r;
          if (in_hs_s) begin
            load_p0_s    = 1'b1;
            state_next_s = ST_ODD;
          end else begin
            state_next_s = ST_EVEN;
          end
        end else begin
          state_next_s = ST_SECOND;
        end
      end
      default: begin
        state_next_s = ST_EVEN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r <= ST_EVEN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pixel, pending-word, output-word and error registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      p0_y_r       <= 8'h00;
      p0_cb_r      <= 8'h00;
      p0_cr_r      <= 8'h00;
      p0_sol_r     <= 1'b0;
      pend_r       <= 16'h0000;
      pend_valid_r <= 1'b0;
      word_r       <= 16'h0000;
      sol_r        <= 1'b0;
      valid_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      if (load_p0_s) begin
        p0_y_r   <= iY;
        p0_cb_r  <= iCb;
        p0_cr_r  <= iCr;
        p0_sol_r <= iSOL;
      end
      if (load_word0_s) begin
        word_r       <= pack_word(p0_y_r, c_b_s);
        sol_r        <= p0_sol_r;
        valid_r      <= 1'b1;
        pend_r       <= pack_word(iY, c_r_s);
        pend_valid_r <= 1'b1;
      end else if (load_word1_s) begin
        word_r       <= pend_r;
        sol_r        <= 1'b0;
        valid_r      <= 1'b1;
        pend_valid_r <= 1'b0;
      end else if (out_hs_s) begin
        valid_r <= 1'b0;
      end
      if (set_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign oREADY = ready_s;
  assign oYCbCr = word_r;
  assign oSOL   = sol_r;
  assign oVALID = valid_r;
  assign oERR   = err_r;

endmodule

// File: tb/tb_yuv444_to_yuv422.sv
module tb_yuv444_to_yuv422;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [7:0]  iY, iCb, iCr;
  logic        iSOL, iVALID, iREADY;

  logic        a_ready, a_sol, a_valid, a_err;
  logic [15:0] a_word;
  logic        d_ready, d_sol, d_valid, d_err;
  logic [15:0] d_word;

  yuv444_to_yuv422 #(.AVERAGE(1)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iY(iY), .iCb(iCb), .iCr(iCr), .iSOL(iSOL),
    .iVALID(iVALID), .oREADY(a_ready), .oYCbCr(a_word), .oSOL(a_sol),
    .oVALID(a_valid), .iREADY(iREADY), .oERR(a_err)
  );

  yuv444_to_yuv422 #(.AVERAGE(0)) dut_d (
    .iCLK(iCLK), .iRST(iRST), .iY(iY), .iCb(iCb), .iCr(iCr), .iSOL(iSOL),
    .iVALID(iVALID), .oREADY(d_ready), .oYCbCr(d_word), .oSOL(d_sol),
    .oVALID(d_valid), .iREADY(iREADY), .oERR(d_err)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        s;
    logic [15:0] w;
  } exp_t;

  typedef struct packed {
    logic [7:0]  y0, cb0, cr0, y1, cb1, cr1;
    logic [15:0] ea0, ea1, ed0, ed1;
  } vec_t;

  exp_t qa[$];
  exp_t qd[$];
  vec_t vecs[4];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls = 0;
  int hs_first = -1;
  int hs_last = -1;
  logic mark = 1'b0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b) + 1;
    return 8'(s / 2);
  endfunction

  // Expected words for a pair, derived independently for both DUT variants.
  task automatic push_pair(input logic [7:0] y0, cb0, cr0, y1, cb1, cr1, input logic sol0);
    qa.push_back({sol0, y0, avg(cb0, cb1)});
    qa.push_back({1'b0, y1, avg(cr0, cr1)});
    qd.push_back({sol0, y0, cb0});
    qd.push_back({1'b0, y1, cr0});
  endtask

  task automatic send(input logic [7:0] y, cb, cr, input logic sol);
    int n;
    iY = y; iCb = cb; iCr = cr; iSOL = sol; iVALID = 1'b1;
    n = 0;
    @(negedge iCLK);
    while (!a_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge iCLK);
    end
    if (!a_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready=%b expected 1", a_ready);
    end
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    iSOL = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qd.size() != 0) && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    chk("drain_left", qa.size() + qd.size(), 0);
    @(posedge iCLK);
    #1;
  endtask

  // Output monitor: every output handshake pops and compares one expected word.
  always @(negedge iCLK) begin
    exp_t e;
    if (!iRST && iREADY) begin
      if (a_valid) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected: got %h expected none", a_word);
        end else begin
          e = qa.pop_front();
          chk("a_word", {15'd0, a_sol, a_word}, {15'd0, e});
          if (mark) begin
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
          end
        end
      end
      if (d_valid) begin
        if (qd.size() == 0) begin
          total++; bad++;
          $display("FAIL d_unexpected: got %h expected none", d_word);
        end else begin
          e = qd.pop_front();
          chk("d_word", {15'd0, d_sol, d_word}, {15'd0, e});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h0A, 8'h64, 8'h32, 8'h14, 8'h67, 8'h3D, 16'h0A66, 16'h1438, 16'h0A64, 16'h1432};
    vecs[1] = '{8'h01, 8'hFF, 8'h00, 8'h02, 8'hFF, 8'h01, 16'h01FF, 16'h0201, 16'h01FF, 16'h0200};
    vecs[2] = '{8'h03, 8'h00, 8'hC8, 8'h04, 8'h01, 8'hC9, 16'h0301, 16'h04C9, 16'h0300, 16'h04C8};
    vecs[3] = '{8'h55, 8'h10, 8'h80, 8'h66, 8'h20, 8'h81, 16'h5518, 16'h6681, 16'h5510, 16'h6680};

    iRST = 1'b1; iY = 8'h00; iCb = 8'h00; iCr = 8'h00;
    iSOL = 1'b0; iVALID = 1'b0; iREADY = 1'b1;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_word", a_word, 16'h0000);
    chk("rst_err", a_err, 1'b0);
    chk("rst_ready", a_ready, 1'b1);

    // Table-driven pairs: basic, rounding edges, generic.
    @(posedge iCLK); #1;
    for (int i = 0; i < 4; i++) begin
      qa.push_back({1'b1, vecs[i].ea0});
      qa.push_back({1'b0, vecs[i].ea1});
      qd.push_back({1'b1, vecs[i].ed0});
      qd.push_back({1'b0, vecs[i].ed1});
      send(vecs[i].y0, vecs[i].cb0, vecs[i].cr0, 1'b1);
      send(vecs[i].y1, vecs[i].cb1, vecs[i].cr1, 1'b0);
    end
    drain();

    // Full-rate stream of 8 pixels.
    stalls = 0; hs_first = -1; hs_last = -1; mark = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push_pair(8'(32*j+1), 8'(60*j), 8'(255-14*j), 8'(32*j+17), 8'(60*j+31), 8'(248-14*j), (j == 0));
      send(8'(32*j+1), 8'(60*j), 8'(255-14*j), (j == 0));
      send(8'(32*j+17), 8'(60*j+31), 8'(248-14*j), 1'b0);
    end
    drain();
    mark = 1'b0;
    chk("stream_stalls", stalls, 0);
    chk("stream_span", hs_last - hs_first + 1, 8);

    // Backpressure: word0 held five cycles, a further pixel waits.
    iREADY = 1'b0;
    push_pair(8'h30, 8'h40, 8'h50, 8'h31, 8'h42, 8'h53, 1'b1);
    send(8'h30, 8'h40, 8'h50, 1'b1);
    send(8'h31, 8'h42, 8'h53, 1'b0);
    push_pair(8'h32, 8'h44, 8'h56, 8'h33, 8'h46, 8'h59, 1'b1);
    fork
      begin
        send(8'h32, 8'h44, 8'h56, 1'b1);
        send(8'h33, 8'h46, 8'h59, 1'b0);
      end
      begin
        repeat (5) begin
          @(negedge iCLK);
          chk("bp_word", a_word, 16'h3041);
          chk("bp_valid", a_valid, 1'b1);
          chk("bp_ready", a_ready, 1'b0);
        end
        @(posedge iCLK);
        #1 iREADY = 1'b1;
      end
    join
    drain();

    // Odd-length line: third pixel is orphaned by the next start of line.
    push_pair(8'h40, 8'h10, 8'h20, 8'h41, 8'h12, 8'h22, 1'b1);
    send(8'h40, 8'h10, 8'h20, 1'b1);
    send(8'h41, 8'h12, 8'h22, 1'b0);
    send(8'h42, 8'h14, 8'h24, 1'b0);
    @(negedge iCLK);
    chk("odd_err_before", a_err, 1'b0);
    push_pair(8'h50, 8'h21, 8'h31, 8'h51, 8'h24, 8'h34, 1'b1);
    send(8'h50, 8'h21, 8'h31, 1'b1);
    @(negedge iCLK);
    chk("odd_err_a", a_err, 1'b1);
    chk("odd_err_d", d_err, 1'b1);
    send(8'h51, 8'h24, 8'h34, 1'b0);
    drain();
    chk("odd_err_sticky", a_err, 1'b1);

    // Reset mid-stream with a word waiting on the output.
    iREADY = 1'b0;
    send(8'h60, 8'h70, 8'h80, 1'b1);
    send(8'h61, 8'h71, 8'h81, 1'b0);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("mrst_valid", a_valid, 1'b0);
    chk("mrst_word", a_word, 16'h0000);
    chk("mrst_err", a_err, 1'b0);
    chk("mrst_ready", a_ready, 1'b1);
    @(posedge iCLK);
    #1 iRST = 1'b0; iREADY = 1'b1;
    push_pair(8'h70, 8'h02, 8'h04, 8'h71, 8'h05, 8'h08, 1'b1);
    send(8'h70, 8'h02, 8'h04, 1'b1);
    send(8'h71, 8'h05, 8'h08, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yuv444_to_yuv422.md
Name: yuv444_to_yuv422

Overview:
- Packs a 4:4:4 pixel stream (separate 8-bit Y, Cb, Cr) into a 16-bit 4:2:2 word stream, one word per pixel.
- It is the transmit-side counterpart of the 4:2:2-to-4:4:4 unpacker and uses the same word layout:
  - even word = {Y, Cb}
  - odd word = {Y, Cr}
- Sits between the processing pipeline and the 4:2:2 video sink or frame-buffer writer.
- Valid/ready on both sides; line-aligned chroma pairing; optional 2-tap chroma averaging.

Parameters:
- AVERAGE, 1.
  - 1: chroma = rounded mean of the pixel pair.
  - 0: co-sited decimation; Cb and Cr are both taken from the even pixel.

Ports:
- iCLK, input, 1: clock.
- iRST, input, 1: asynchronous reset, active-high.
- iY, input, 8: luma of input pixel.
- iCb, input, 8: blue-difference chroma of input pixel.
- iCr, input, 8: red-difference chroma of input pixel.
- iSOL, input, 1: start of line; qualifies the current input pixel as the first of a line.
- iVALID, input, 1: input pixel valid.
- oREADY, output, 1: block can accept an input pixel this cycle.
- oYCbCr, output, 16: packed word, [15:8] = Y, [7:0] = Cb or Cr.
- oSOL, output, 1: current output word is the first word of a line.
- oVALID, output, 1: output word valid.
- iREADY, input, 1: downstream accepts the output word.
- oERR, output, 1: sticky flag; a line with an odd pixel count was seen.

Behaviour:
- Definitions:
  - Input handshake = iVALID & oREADY.
  - Output handshake = oVALID & iREADY.
- Reset (asynchronous, iRST=1):
  - state = EVEN.
  - oVALID=0, oYCbCr=0, oSOL=0, oERR=0.
  - All pixel and pending registers = 0.
- Internal storage:
  - P0 register holds {Y0, Cb0, Cr0, sol0}.
  - PEND register holds the second word of a pair plus a valid bit.
- oREADY:
  - In EVEN and ODD: oREADY = !oVALID | iREADY.
  - In SECOND: oREADY = iREADY. This is a combinational path from iREADY; it is permitted.
- State EVEN (no pixel held):
  - On input handshake: capture the pixel into P0; go to ODD.
- State ODD (P0 held):
  - Input handshake with iSOL=0:
    - Load oYCbCr <= {Y0, C_b} and oSOL <= sol0; set oVALID.
    - Load PEND <= {Y1, C_r}.
    - Go to SECOND.
  - Input handshake with iSOL=1 (orphan pixel):
    - Discard the P0 contents; set oERR.
    - Capture the new pixel into P0; stay in ODD.
  - If an output handshake occurs in the same cycle, oVALID clears unless a new word is loaded.
- State SECOND (word0 on output, word1 in PEND):
  - On output handshake: oYCbCr <= PEND, oSOL <= 0, oVALID stays 1.
  - If an input handshake occurs in the same cycle: capture the pixel into P0 and go to ODD. Otherwise go to EVEN.
  - With no output handshake: hold everything.
- Output word clearing:
  - In EVEN/ODD, an output handshake with no new word loaded clears oVALID.
- Chroma arithmetic:
  - AVERAGE=1:
    - C_b = (Cb0 + Cb1 + 1) >> 1, computed in 9 bits and truncated to 8. No overflow is possible; the maximum is 255.
    - C_r = (Cr0 + Cr1 + 1) >> 1.
  - AVERAGE=0: C_b = Cb0, C_r = Cr0.
- Latency and throughput:
  - Word0 is valid the cycle after the odd pixel's input handshake.
  - Word1 is valid the cycle after word0's output handshake.
  - Sustained rate is 1 pixel/cycle when iREADY=1 constantly.
- Output stability:
  - oYCbCr and oSOL are stable while oVALID=1 and iREADY=0.
- Reset mid-line: P0, PEND and the output word are dropped; restart in EVEN.
- oERR clears only on reset.

Decomposition:
- Shared package yuv_pkg:
  - State encoding ST_EVEN, ST_ODD, ST_SECOND (2-bit).
  - Word-field constants: Y_MSB=15, Y_LSB=8, C_MSB=7, C_LSB=0.
  - Shared with the 4:2:2-to-4:4:4 unpacker.
- One sub-module, chroma_avg2: two 8-bit inputs, AVERAGE parameter, one 8-bit output. Instantiated twice, once for Cb and once for Cr.

Test Plan:
- Reset: assert iRST mid-stream -> next cycle oVALID=0, oYCbCr=16'h0000, oERR=0, oREADY=1.
- Basic pair, AVERAGE=1:
  - Stimulus: pixels (Y,Cb,Cr) = (10,100,50) with iSOL=1, then (20,103,61).
  - Expected: 16'h0A66 with oSOL=1, then 16'h1438 with oSOL=0.
- Decimate, AVERAGE=0: same stimulus -> 16'h0A64 then 16'h1432.
- Full-rate stream:
  - Stimulus: 8 pixels back-to-back, iREADY=1.
  - Expected: 8 words, no bubbles after the first, oREADY stays 1.
- Backpressure: iREADY=0 for 5 cycles while word0 is valid -> oYCbCr held, oREADY=0, no data loss; release -> words in order.
- Odd-length line:
  - Stimulus: 3 pixels, then a pixel with iSOL=1.
  - Expected: only one pair emitted from the first line, oERR=1, next line pairs correctly.
- Rounding edge, AVERAGE=1: Cb pair (255,255) -> 8'hFF; Cb pair (0,1) -> 8'h01.
